// File: rtl/fetch_prefetch_pkg.sv
// Shared definitions for the buffered fetch stage: queue entry layout, NOP word and reset PC.
package fetch_prefetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_chk.sv
// Protocol checks for the prefetch stage: queue never overflows, in-flight requests stay bounded.
module fetch_prefetch_chk #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                                 CLK,
    input logic                                 RST,
    input logic                                 i_q_push,
    input logic                                 i_q_pop,
    input logic [$clog2(DEPTH+1)-1:0]           i_q_count,
    input logic [$clog2(MAX_OUTSTANDING+1)-1:0] i_outstanding
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(i_q_push && !i_q_pop && (i_q_count == CW'(DEPTH))));

    a_outstanding_bound: assert property (@(posedge CLK) disable iff (RST)
        i_outstanding <= OW'(MAX_OUTSTANDING));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Generic synchronous FIFO with flush; holds fetched entries or in-flight request PCs.
module fetch_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge CLK) begin
        if (RST || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// Buffered fetch stage: credit-limited imem request issue, in-order response capture into a
// prefetch queue, and redirect handling that discards responses of squashed requests.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_En,
    input  logic        PC_Src_E,
    input  logic [31:0] PC_Target_E,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_RValid,
    input  logic [31:0] Imem_RData,
    output logic        Valid_F,
    input  logic        Ready_D,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   r_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;

    logic [CW-1:0] w_q_count;
    fetch_entry_t  w_q_head;
    fetch_entry_t  w_q_data;
    logic [OW-1:0] w_f_count;
    logic [31:0]   w_f_pc;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_grant;
    logic          w_rvalid;
    logic          w_stale;
    logic          w_fresh;
    logic          w_push;
    logic          w_pop;

    // Credit: every issued request already owns a queue slot, so responses never need stalling.
    assign w_occupancy = {1'b0, w_q_count} + (CW+1)'(r_outstanding);
    assign w_req       = !RST && PC_En && !PC_Src_E
                         && (r_outstanding < OW'(MAX_OUTSTANDING))
                         && (w_occupancy < (CW+1)'(DEPTH));
    assign w_grant     = w_req && Imem_Gnt;
    assign w_rvalid    = Imem_RValid && !RST;
    assign w_stale     = w_rvalid && (r_discard != '0);
    assign w_fresh     = w_rvalid && !w_stale;
    assign w_push      = w_fresh && !PC_Src_E;
    assign w_pop       = Valid_F && Ready_D;

    assign w_q_data.pc    = w_f_pc;
    assign w_q_data.instr = Imem_RData;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= RESET_PC;
        end else if (PC_Src_E) begin
            r_pc <= word_align(PC_Target_E);
        end else if (w_grant) begin
            r_pc <= r_pc + 32'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    // On redirect every request still in flight is stale, except one answered this very cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_grant) - OW'(w_rvalid);
            if (PC_Src_E) begin
                r_discard <= r_outstanding - OW'(w_rvalid);
            end else if (w_stale) begin
                r_discard <= r_discard - OW'(1);
            end else begin
                r_discard <= r_discard;
            end
        end
    end

    fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [31:0])
    ) u_inflight_pc (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_grant),
        .i_data  (r_pc),
        .i_pop   (w_fresh),
        .i_flush (PC_Src_E),
        .o_head  (w_f_pc),
        .o_count (w_f_count)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_prefetch_q (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_data  (w_q_data),
        .i_pop   (w_pop),
        .i_flush (PC_Src_E),
        .o_head  (w_q_head),
        .o_count (w_q_count)
    );

    fetch_prefetch_chk #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .CLK           (CLK),
        .RST           (RST),
        .i_q_push      (w_push),
        .i_q_pop       (w_pop),
        .i_q_count     (w_q_count),
        .i_outstanding (w_f_count + r_discard)
    );

    assign Imem_Req  = w_req;
    assign Imem_Addr = r_pc;
    assign Valid_F   = (w_q_count != '0);

    always_comb begin
        Instr_F     = NOP_INSTR;
        PC_F        = 32'd0;
        PC_Plus_4_F = 32'd0;
        if (Valid_F) begin
            Instr_F     = w_q_head.instr;
            PC_F        = w_q_head.pc;
            PC_Plus_4_F = w_q_head.pc + 32'd4;
        end else begin
            Instr_F     = NOP_INSTR;
            PC_F        = 32'd0;
            PC_Plus_4_F = 32'd0;
        end
    end

endmodule
